// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared constants for the instruction fetch queue: machine
//               word width, its log2, boolean constants and the NOP encoding
//               (addi x0, x0, 0) presented to decode when no entry is valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

    localparam int          XLEN       = 32;
    localparam int          XLEN_WIDTH = 5;
    localparam logic        TRUE       = 1'b1;
    localparam logic        FALSE      = 1'b0;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue_buf.sv
// ============================================================================
// Module      : fetch_queue_buf
// Description : Entry storage for the fetch queue. DEPTH x WIDTH register
//               array, one synchronous write port, one combinational read
//               port, no reset (contents are qualified by the queue count).
// Ports       : clk   - clock
//               we    - write enable
//               waddr - write index
//               wdata - write data ({address, instruction})
//               raddr - read index
//               rdata - read data, combinational
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fetch_queue_buf

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue. A fetch PC addresses a combinational
//               instruction RAM; each fetched word is queued together with its
//               address and handed to decode in strict fetch order. A jump
//               flushes the queue and redirects the fetch PC.
// Config      : FETCH_QUEUE_BYPASS_EN - when defined, an empty queue presents
//               the RAM word to decode in the same cycle it is fetched.
// Ports       : clk       - clock (rising edge)
//               rst       - asynchronous active-high reset
//               jump      - redirect request
//               jump_addr - redirect target (low two bits ignored)
//               ram_addr  - instruction RAM read address
//               ram_data  - instruction RAM read data (same cycle)
//               out_valid - head entry available
//               out_inst  - head instruction word
//               out_addr  - head instruction address
//               out_ready - decode accepts the head this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_addr,
    output logic [31:0]     ram_addr,
    input  logic [31:0]     ram_data,
    output logic            out_valid,
    output logic [31:0]     out_inst,
    output logic [31:0]     out_addr,
    input  logic            out_ready
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  COUNT_MAX = CW'(DEPTH);
    localparam logic [31:0]    ALIGN_MASK = 32'hFFFF_FFFC;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic [63:0]   head_entry;

    logic queue_valid;
    logic bypass;
    logic bypass_take;
    logic pop;
    logic push;
    logic advance;

    assign queue_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Gated by rst so outputs stay idle for the whole reset interval.
    assign bypass      = !rst && !queue_valid && !jump;
`else
    assign bypass      = 1'b0;
`endif

    // A bypassed word that decode takes is consumed and never enters storage.
    assign bypass_take = bypass && out_ready;
    assign pop         = queue_valid && out_ready && !jump;
    assign push        = !jump && !bypass_take && ((count != COUNT_MAX) || pop);
    assign advance     = push || bypass_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_ADDR & ALIGN_MASK;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (jump) begin
            fetch_pc <= jump_addr & ALIGN_MASK;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (advance) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    fetch_queue_buf #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_buf (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata ({fetch_pc, ram_data}),
        .raddr (head),
        .rdata (head_entry)
    );

    assign ram_addr = fetch_pc;

    always_comb begin
        out_valid = 1'b0;
        out_inst  = INST_NOP;
        out_addr  = '0;
        if (queue_valid) begin
            out_valid = 1'b1;
            out_inst  = head_entry[31:0];
            out_addr  = head_entry[63:32];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_inst  = ram_data;
            out_addr  = fetch_pc;
        end
    end

endmodule : fetch_queue

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001: Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two and at least 2.
- REQ-002: Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset; SHALL be asynchronous and active-high.
- REQ-005: jump  input  1  redirect request from execute.
- REQ-006: jump_addr  input  XLEN (32)  redirect target.
- REQ-007: ram_addr  output  32  instruction read address to the RAM read port.
- REQ-008: ram_data  input  32  instruction word; combinational, same cycle as ram_addr.
- REQ-009: out_valid  output  1  head entry available to decode.
- REQ-010: out_inst  output  32  head instruction word.
- REQ-011: out_addr  output  32  address of the head instruction.
- REQ-012: out_ready  input  1  decode accepts the head this cycle (driven as !pause).

Function
- REQ-013: An internal fetch_pc register SHALL drive ram_addr directly; ram_addr[1:0] SHALL always be 0.
- REQ-014: Push occurs in a cycle when jump=0 and (count<DEPTH or a pop occurs the same cycle); the pushed entry is {fetch_pc, ram_data}, and fetch_pc SHALL advance by 4 (mod 2^32).
- REQ-015: When no push occurs, fetch_pc SHALL hold.
- REQ-016: Pop occurs when out_valid=1, out_ready=1 and jump=0; the head pointer advances by one (mod DEPTH).
- REQ-017: out_valid SHALL equal (count!=0); when out_valid=0, out_inst SHALL be INST_NOP and out_addr SHALL be 0.
- REQ-018: Push and pop in the same cycle SHALL leave count unchanged, including when count=DEPTH.
- REQ-019: Head and tail pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.
- REQ-020: With jump=1, the following SHALL hold at the next edge: count=0, both pointers=0, fetch_pc={jump_addr[31:2],2'b00}; no push or pop occurs in that cycle.
- REQ-021: jump SHALL take priority over push, pop and full/empty conditions.
- REQ-022: The minimum latency from a fetch address to out_valid SHALL be one cycle (without bypass).
- REQ-023: Entries SHALL leave in strict fetch order; no entry is dropped except by jump or rst.

Reset
- REQ-024: While rst=1, the following SHALL hold: fetch_pc=RESET_ADDR, count=0, both pointers=0, out_valid=0, out_inst=INST_NOP, out_addr=0.
- REQ-025: Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
- REQ-026: After rst deasserts, the first push SHALL occur on the first rising edge.

Configuration
- REQ-027: Macro FETCH_QUEUE_BYPASS_EN: when defined and count=0 and jump=0, out_valid=1, out_inst=ram_data and out_addr=fetch_pc combinationally.
- REQ-028: With bypass active and out_ready=1, the word SHALL be consumed and not pushed, and fetch_pc SHALL advance by 4.
- REQ-029: With bypass active and out_ready=0, the word SHALL be pushed normally.
- REQ-030: Without FETCH_QUEUE_BYPASS_EN, REQ-017 and REQ-022 SHALL apply unchanged.

Structure
- REQ-031: XLEN, XLEN_WIDTH, true/false SHALL come from define/const.v; INST_NOP SHALL come from define/inst.v; no new global constants SHALL be added.
- REQ-032: Entry storage SHALL be one sub-module, fetch_queue_buf: a DEPTH x 64-bit register array with one write port and one combinational read port, reset-free.
- REQ-033: Pointer, count and fetch_pc logic SHALL stay in fetch_queue.

Verification
- REQ-034: Reset release, RESET_ADDR=0, out_ready=0 -> ram_addr 0,4,8,12, then holds at 16; count=4; out_addr=0.
- REQ-035: Full queue, out_ready=1 continuously -> one pop and one push per cycle; out_addr sequence 0,4,8,...; count stays 4.
- REQ-036: jump=1, jump_addr=32'h103 while count=3 -> next cycle out_valid=0, ram_addr=32'h100; following cycle out_addr=32'h100.
- REQ-037: jump and out_ready asserted in the same cycle while full -> no pop counted, queue empty next cycle, no stale address appears.
- REQ-038: rst pulsed asynchronously mid-cycle with count=2 -> out_valid=0 and out_inst=INST_NOP before the next edge.
- REQ-039: With FETCH_QUEUE_BYPASS_EN, empty queue, out_ready=1, ram_data=32'h00500093 -> same-cycle out_valid=1, out_inst=32'h00500093; count remains 0.
